// File: rtl/mem_stage.sv
// Memory stage of the 5-stage MIPS pipeline: X/M and M/W registers, data-memory handshake
// with timeout, byte load extension, byte store replication and M/W -> X/M store-data forwarding.
module mem_stage #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [31:0] ex_result,
   input  logic [31:0] ex_store_data,
   input  logic [4:0]  ex_rt,
   input  logic [4:0]  ex_dest_reg,
   input  logic        ex_reg_we,
   input  logic        ex_load,
   input  logic        ex_store,
   input  logic        ex_byte,
   input  logic        ex_ubyte,
   output logic        stall_out,
   output logic        mem_req,
   output logic        mem_wren,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_byte_only,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   output logic        wb_reg_we,
   output logic [4:0]  wb_dest_reg,
   output logic [31:0] wb_data,
   output logic        bus_err
);

   // Buses are numbered [31:0] here; MSB-0 bit i is bit 31-i, so the byte offset is addr[1:0]
   // and offset 0 selects the most significant byte (big-endian).
   localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

   typedef struct packed {
      logic        valid;
      logic [31:0] result;
      logic [31:0] store_data;
      logic [4:0]  dest_reg;
      logic        reg_we;
      logic        load;
      logic        store;
      logic        byte_acc;
      logic        ubyte;
   } xm_t;

   typedef struct packed {
      logic        valid;
      logic        reg_we;
      logic [4:0]  dest_reg;
      logic [31:0] data;
   } mw_t;

   typedef enum logic {IDLE, WAIT} state_t;

   xm_t         xm, xm_n;
   mw_t         mw, mw_n;
   state_t      state, state_n;
   logic [7:0]  cnt, cnt_n;
   logic        mem_op, misalign, tmo_hit, issue, fwd;
   logic [7:0]  ld_byte;
   logic [31:0] ld_data;

   always_comb begin
      mem_op   = xm.valid & (xm.load | xm.store);
      misalign = mem_op & ~xm.byte_acc & (xm.result[1:0] != 2'b00);
      tmo_hit  = (state == WAIT) & (cnt == TMO);
      issue    = mem_op & ~misalign & ~tmo_hit;
   end

   assign mem_req       = issue;
   assign stall_out     = issue & ~mem_ack;
   assign bus_err       = mem_op & (misalign | tmo_hit);
   assign mem_wren      = issue & xm.store;
   assign mem_byte_only = issue & xm.byte_acc;
   assign mem_addr      = xm.result;
   assign mem_wdata     = xm.byte_acc ? {4{xm.store_data[7:0]}} : xm.store_data;

   assign wb_valid    = mw.valid;
   assign wb_reg_we   = mw.reg_we;
   assign wb_dest_reg = mw.dest_reg;
   assign wb_data     = mw.data;

   // Load result still sitting in M/W replaces the bypassed rt value of a store entering X/M.
   assign fwd = ex_store & mw.valid & mw.reg_we & (ex_rt == mw.dest_reg) & (mw.dest_reg != 5'd0);

   always_comb begin
      xm_n = xm;
      if (!stall_out) begin
         xm_n.valid      = ex_valid;
         xm_n.result     = ex_result;
         xm_n.store_data = fwd ? mw.data : ex_store_data;
         xm_n.dest_reg   = ex_dest_reg;
         xm_n.reg_we     = ex_reg_we;
         xm_n.load       = ex_load;
         xm_n.store      = ex_store;
         xm_n.byte_acc   = ex_byte;
         xm_n.ubyte      = ex_ubyte;
      end
   end

   always_comb begin
      case (xm.result[1:0])
         2'd0:    ld_byte = mem_rdata[31:24];
         2'd1:    ld_byte = mem_rdata[23:16];
         2'd2:    ld_byte = mem_rdata[15:8];
         default: ld_byte = mem_rdata[7:0];
      endcase
      if (xm.byte_acc)
         ld_data = {(xm.ubyte ? 24'd0 : {24{ld_byte[7]}}), ld_byte};
      else
         ld_data = mem_rdata;
   end

   // Stall, misalign and timeout cycles all push a bubble so each instruction writes back once.
   always_comb begin
      mw_n.valid    = xm.valid & (~mem_op | (issue & mem_ack));
      mw_n.reg_we   = mw_n.valid & xm.reg_we & ~xm.store;
      mw_n.dest_reg = xm.dest_reg;
      mw_n.data     = (mem_op & xm.load) ? ld_data : xm.result;
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (stall_out) begin
               state_n = WAIT;
               cnt_n   = 8'd1;
            end
         end
         WAIT: begin
            if (tmo_hit || (issue && mem_ack) || !mem_op) begin
               state_n = IDLE;
               cnt_n   = 8'd0;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         xm    <= '0;
         mw    <= '0;
         state <= IDLE;
         cnt   <= 8'd0;
      end else begin
         xm    <= xm_n;
         mw    <= mw_n;
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

endmodule
